// File: rtl/fetch_issue_splitter_pkg.sv
// Shared types and constants for the fetch issue splitter.
// Lane width defaults match the top-level parameter defaults.
package fetch_issue_splitter_pkg;

  localparam int GROUP_N = 4;
  localparam int ISSUE_N = 2;
  localparam int INST_W_DEF = 32;
  localparam int PC_W_DEF = 32;
  localparam int PC_STEP_DEF = 4;

  typedef struct packed {
    logic                  valid;
    logic [INST_W_DEF-1:0] inst;
    logic [PC_W_DEF-1:0]   pc;
  } issue_lane_t;

  function automatic logic [2:0] popcount4(
    input logic [GROUP_N-1:0] m
  );
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < GROUP_N; i++) begin
      n = n + {2'b00, m[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/fetch_lane_pick.sv
// Picks the two oldest pending slots from the remaining mask.
// Outputs one-hot lane selects and the union of issued slots.
module fetch_lane_pick
  import fetch_issue_splitter_pkg::*;
(
  input  logic [GROUP_N-1:0] rem_mask,
  output logic [GROUP_N-1:0] lane0_sel,
  output logic [GROUP_N-1:0] lane1_sel,
  output logic [GROUP_N-1:0] issued_mask
);

  logic [GROUP_N-1:0] rest;

  always_comb begin
    // x & -x isolates the lowest set bit
    lane0_sel   = rem_mask & (-rem_mask);
    rest        = rem_mask & ~lane0_sel;
    lane1_sel   = rest & (-rest);
    issued_mask = lane0_sel | lane1_sel;
  end

endmodule

// File: rtl/fetch_issue_splitter.sv
// Splits a 4-slot fetch group into up to two in-order issues per cycle.
// Optional SPLITTER_PERF_CNT_EN adds issue/stall performance counters.
module fetch_issue_splitter
  import fetch_issue_splitter_pkg::*;
#(
  parameter int INST_W  = INST_W_DEF,
  parameter int PC_W    = PC_W_DEF,
  parameter int PC_STEP = PC_STEP_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [4*INST_W-1:0]   inst_group,
  input  logic [3:0]            inst_group_valid,
  input  logic [PC_W-1:0]       group_pc,
  input  logic                  pre_valid,
  output logic                  out_ready,
  output logic [INST_W-1:0]     inst0,
  output logic [INST_W-1:0]     inst1,
  output logic [PC_W-1:0]       pc0,
  output logic [PC_W-1:0]       pc1,
  output logic [1:0]            issue_valid,
  output logic                  out_valid,
  input  logic                  next_ready
`ifdef SPLITTER_PERF_CNT_EN
  ,
  output logic [31:0]           perf_issue_cnt,
  output logic [31:0]           perf_stall_cnt
`endif
);

  logic [INST_W-1:0]  slot_q [GROUP_N];
  logic [INST_W-1:0]  slot_d [GROUP_N];
  logic [PC_W-1:0]    base_pc_q;
  logic [PC_W-1:0]    base_pc_d;
  logic [GROUP_N-1:0] rem_mask_q;
  logic [GROUP_N-1:0] rem_mask_d;

  logic [GROUP_N-1:0] lane0_sel;
  logic [GROUP_N-1:0] lane1_sel;
  logic [GROUP_N-1:0] issued_mask;
  logic               fire;
  logic               accept;

  fetch_lane_pick u_pick (
    .rem_mask    (rem_mask_q),
    .lane0_sel   (lane0_sel),
    .lane1_sel   (lane1_sel),
    .issued_mask (issued_mask)
  );

  always_comb begin
    inst0 = '0;
    inst1 = '0;
    pc0   = '0;
    pc1   = '0;
    for (int i = 0; i < GROUP_N; i++) begin
      if (lane0_sel[i]) begin
        inst0 = slot_q[i];
        pc0   = base_pc_q + PC_W'(i * PC_STEP);
      end
      if (lane1_sel[i]) begin
        inst1 = slot_q[i];
        pc1   = base_pc_q + PC_W'(i * PC_STEP);
      end
    end
    issue_valid = {|lane1_sel, |lane0_sel};
    out_valid   = issue_valid[0];
  end

  always_comb begin
    fire = out_valid && next_ready;
    // a fire that drains the group frees the buffer this cycle
    out_ready = !flush && (rem_mask_q == '0 ||
                (fire && popcount4(rem_mask_q) <= 3'd2));
    accept = pre_valid && out_ready;
  end

  always_comb begin
    slot_d     = slot_q;
    base_pc_d  = base_pc_q;
    rem_mask_d = rem_mask_q;
    if (fire) begin
      rem_mask_d = rem_mask_q & ~issued_mask;
    end
    if (accept) begin
      for (int i = 0; i < GROUP_N; i++) begin
        slot_d[i] = inst_group[i*INST_W +: INST_W];
      end
      base_pc_d  = group_pc;
      rem_mask_d = inst_group_valid;
    end
    if (flush) begin
      rem_mask_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < GROUP_N; i++) begin
        slot_q[i] <= '0;
      end
      base_pc_q  <= '0;
      rem_mask_q <= '0;
    end else begin
      slot_q     <= slot_d;
      base_pc_q  <= base_pc_d;
      rem_mask_q <= rem_mask_d;
    end
  end

`ifdef SPLITTER_PERF_CNT_EN
  logic [31:0] issue_cnt_q;
  logic [31:0] issue_cnt_d;
  logic [31:0] stall_cnt_q;
  logic [31:0] stall_cnt_d;

  always_comb begin
    issue_cnt_d = issue_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (fire) begin
      issue_cnt_d = issue_cnt_q
                  + {31'b0, issue_valid[0]}
                  + {31'b0, issue_valid[1]};
    end
    if (out_valid && !next_ready) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      issue_cnt_q <= issue_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign perf_issue_cnt = issue_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_issue_splitter.sv
// Self-checking bench for fetch_issue_splitter: directed scenarios
// plus randomized traffic against a queue-based reference model.
module tb_fetch_issue_splitter;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         flush = 1'b0;
  logic [127:0] inst_group = '0;
  logic [3:0]   inst_group_valid = '0;
  logic [31:0]  group_pc = '0;
  logic         pre_valid = 1'b0;
  logic         next_ready = 1'b0;
  logic         out_ready;
  logic [31:0]  inst0;
  logic [31:0]  inst1;
  logic [31:0]  pc0;
  logic [31:0]  pc1;
  logic [1:0]   issue_valid;
  logic         out_valid;
`ifdef SPLITTER_PERF_CNT_EN
  logic [31:0]  perf_issue_cnt;
  logic [31:0]  perf_stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  // {out_valid, out_ready, issue_valid, inst0, inst1, pc0, pc1}
  wire [131:0] obs = {out_valid, out_ready, issue_valid,
                      inst0, inst1, pc0, pc1};
  logic [131:0] exp;

  fetch_issue_splitter dut (
    .clk              (clk),
    .rst              (rst),
    .flush            (flush),
    .inst_group       (inst_group),
    .inst_group_valid (inst_group_valid),
    .group_pc         (group_pc),
    .pre_valid        (pre_valid),
    .out_ready        (out_ready),
    .inst0            (inst0),
    .inst1            (inst1),
    .pc0              (pc0),
    .pc1              (pc1),
    .issue_valid      (issue_valid),
    .out_valid        (out_valid),
    .next_ready       (next_ready)
`ifdef SPLITTER_PERF_CNT_EN
    ,
    .perf_issue_cnt   (perf_issue_cnt),
    .perf_stall_cnt   (perf_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  localparam logic [131:0] EMPTY = {1'b0, 1'b1, 2'b00, 128'h0};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_group(
    input logic [31:0] a, input logic [31:0] b,
    input logic [31:0] c, input logic [31:0] d,
    input logic [3:0] m, input logic [31:0] pc
  );
    inst_group       = {d, c, b, a};
    inst_group_valid = m;
    group_pc         = pc;
  endtask

  task automatic do_reset();
    flush      = 1'b0;
    pre_valid  = 1'b0;
    next_ready = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    exp = EMPTY;
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL reset_out got %h exp %h", obs, exp);
    end
`ifdef SPLITTER_PERF_CNT_EN
    checks++;
    if ({perf_issue_cnt, perf_stall_cnt} !== 64'h0) begin
      errors++;
      $display("FAIL reset_perf got %h/%h exp 0/0",
               perf_issue_cnt, perf_stall_cnt);
    end
`endif
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic_split();
    do_reset();
    set_group(32'hA, 32'hB, 32'hC, 32'hD, 4'b1111, 32'h1C000000);
    pre_valid  = 1'b1;
    next_ready = 1'b1;
    #1;
    exp = EMPTY;
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL basic_c0 got %h exp %h", obs, exp);
    end
    tick();
    pre_valid = 1'b0;
    #1;
    exp = {1'b1, 1'b0, 2'b11, 32'hA, 32'hB,
           32'h1C000000, 32'h1C000004};
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL basic_c1 got %h exp %h", obs, exp);
    end
    tick();
    set_group(32'hE, 32'hF, 32'h10, 32'h11, 4'b1111, 32'h2000);
    pre_valid = 1'b1;
    #1;
    exp = {1'b1, 1'b1, 2'b11, 32'hC, 32'hD,
           32'h1C000008, 32'h1C00000C};
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL basic_c2 got %h exp %h", obs, exp);
    end
    tick();
    pre_valid = 1'b0;
    #1;
    exp = {1'b1, 1'b0, 2'b11, 32'hE, 32'hF, 32'h2000, 32'h2004};
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL basic_c3 got %h exp %h", obs, exp);
    end
    tick();
    #1;
    exp = {1'b1, 1'b1, 2'b11, 32'h10, 32'h11, 32'h2008, 32'h200C};
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL basic_c4 got %h exp %h", obs, exp);
    end
    tick();
    #1;
    exp = EMPTY;
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL basic_end got %h exp %h", obs, exp);
    end
  endtask

  task automatic test_sparse();
    do_reset();
    set_group(32'h50, 32'h51, 32'h52, 32'h53, 4'b1010, 32'h1000);
    pre_valid  = 1'b1;
    next_ready = 1'b1;
    tick();
    set_group(32'h60, 32'h61, 32'h62, 32'h63, 4'b0100, 32'h3000);
    #1;
    exp = {1'b1, 1'b1, 2'b11, 32'h51, 32'h53, 32'h1004, 32'h100C};
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL sparse_1010 got %h exp %h", obs, exp);
    end
    tick();
    pre_valid = 1'b0;
    #1;
    exp = {1'b1, 1'b1, 2'b01, 32'h62, 32'h0, 32'h3008, 32'h0};
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL sparse_0100 got %h exp %h", obs, exp);
    end
    tick();
    #1;
    exp = EMPTY;
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL sparse_end got %h exp %h", obs, exp);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] s0, i0;
    s0 = '0;
    i0 = '0;
    do_reset();
    set_group(32'hA, 32'hB, 32'hC, 32'hD, 4'b1111, 32'h4000);
    pre_valid = 1'b1;
    tick();
`ifdef SPLITTER_PERF_CNT_EN
    s0 = perf_stall_cnt;
    i0 = perf_issue_cnt;
`endif
    set_group(32'h70, 32'h71, 32'h72, 32'h73, 4'b0001, 32'h5000);
    next_ready = 1'b0;
    #1;
    exp = {1'b1, 1'b0, 2'b11, 32'hA, 32'hB, 32'h4000, 32'h4004};
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL bp_stall_ab got %h exp %h", obs, exp);
    end
    tick();
    next_ready = 1'b1;
    #1;
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL bp_fire_ab got %h exp %h", obs, exp);
    end
    tick();
    next_ready = 1'b0;
    #1;
    exp = {1'b1, 1'b0, 2'b11, 32'hC, 32'hD, 32'h4008, 32'h400C};
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL bp_stall_cd got %h exp %h", obs, exp);
    end
    tick();
    next_ready = 1'b1;
    #1;
    exp = {1'b1, 1'b1, 2'b11, 32'hC, 32'hD, 32'h4008, 32'h400C};
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL bp_fire_cd got %h exp %h", obs, exp);
    end
    tick();
    pre_valid = 1'b0;
    #1;
    exp = {1'b1, 1'b1, 2'b01, 32'h70, 32'h0, 32'h5000, 32'h0};
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL bp_next got %h exp %h", obs, exp);
    end
`ifdef SPLITTER_PERF_CNT_EN
    checks++;
    if (perf_stall_cnt - s0 !== 32'd2) begin
      errors++;
      $display("FAIL bp_stall_cnt got %0d exp 2",
               perf_stall_cnt - s0);
    end
    checks++;
    if (perf_issue_cnt - i0 !== 32'd4) begin
      errors++;
      $display("FAIL bp_issue_cnt got %0d exp 4",
               perf_issue_cnt - i0);
    end
`endif
    tick();
    s0 = s0 + i0;
  endtask

  task automatic test_flush();
    logic [31:0] i0;
    i0 = '0;
    do_reset();
`ifdef SPLITTER_PERF_CNT_EN
    i0 = perf_issue_cnt;
`endif
    set_group(32'hA, 32'hB, 32'hC, 32'hD, 4'b1111, 32'h6000);
    pre_valid  = 1'b1;
    next_ready = 1'b1;
    tick();
    pre_valid = 1'b0;
    #1;
    exp = {1'b1, 1'b0, 2'b11, 32'hA, 32'hB, 32'h6000, 32'h6004};
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL flush_ab got %h exp %h", obs, exp);
    end
    tick();
    set_group(32'h80, 32'h81, 32'h82, 32'h83, 4'b1111, 32'h7000);
    pre_valid = 1'b1;
    flush     = 1'b1;
    #1;
    exp = {1'b1, 1'b0, 2'b11, 32'hC, 32'hD, 32'h6008, 32'h600C};
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL flush_cycle got %h exp %h", obs, exp);
    end
    tick();
    flush     = 1'b0;
    pre_valid = 1'b0;
    #1;
    exp = EMPTY;
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL flush_after got %h exp %h", obs, exp);
    end
`ifdef SPLITTER_PERF_CNT_EN
    checks++;
    if (perf_issue_cnt - i0 !== 32'd4) begin
      errors++;
      $display("FAIL flush_issue_cnt got %0d exp 4",
               perf_issue_cnt - i0);
    end
`endif
  endtask

  task automatic test_empty_wrap();
    do_reset();
    set_group(32'h90, 32'h91, 32'h92, 32'h93, 4'b0000, 32'h8000);
    pre_valid  = 1'b1;
    next_ready = 1'b1;
    tick();
    set_group(32'hA0, 32'hA1, 32'hA2, 32'hA3, 4'b0011, 32'hFFFFFFF8);
    #1;
    exp = EMPTY;
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL empty_group got %h exp %h", obs, exp);
    end
    tick();
    set_group(32'hB0, 32'hB1, 32'hB2, 32'hB3, 4'b1100, 32'hFFFFFFF8);
    #1;
    exp = {1'b1, 1'b1, 2'b11, 32'hA0, 32'hA1,
           32'hFFFFFFF8, 32'hFFFFFFFC};
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL wrap_low got %h exp %h", obs, exp);
    end
    tick();
    pre_valid = 1'b0;
    #1;
    exp = {1'b1, 1'b1, 2'b11, 32'hB2, 32'hB3, 32'h0, 32'h4};
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL wrap_high got %h exp %h", obs, exp);
    end
    tick();
  endtask

  task automatic test_async_reset();
    do_reset();
    set_group(32'hA, 32'hB, 32'hC, 32'hD, 4'b1111, 32'h9000);
    pre_valid  = 1'b1;
    next_ready = 1'b0;
    tick();
    pre_valid = 1'b0;
    #1;
    exp = {1'b1, 1'b0, 2'b11, 32'hA, 32'hB, 32'h9000, 32'h9004};
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL arst_hold got %h exp %h", obs, exp);
    end
    #1;
    rst = 1'b1;
    #1;
    exp = EMPTY;
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL arst_immediate got %h exp %h", obs, exp);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    set_group(32'hA, 32'hB, 32'hC, 32'hD, 4'b1111, 32'h1C000000);
    pre_valid  = 1'b1;
    next_ready = 1'b1;
    tick();
    pre_valid = 1'b0;
    #1;
    exp = {1'b1, 1'b0, 2'b11, 32'hA, 32'hB,
           32'h1C000000, 32'h1C000004};
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL arst_after_ab got %h exp %h", obs, exp);
    end
    tick();
    #1;
    exp = {1'b1, 1'b1, 2'b11, 32'hC, 32'hD,
           32'h1C000008, 32'h1C00000C};
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL arst_after_cd got %h exp %h", obs, exp);
    end
    tick();
  endtask

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } ent_t;

  task automatic test_random();
    ent_t        q[$];
    int          n;
    logic        mfire;
    logic        mready;
    logic [31:0] m_issue;
    logic [31:0] m_stall;
    logic [31:0] w [4];
    m_issue = '0;
    m_stall = '0;
    do_reset();
    q.delete();
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int i = 0; i < 4; i++) w[i] = $urandom;
      set_group(w[0], w[1], w[2], w[3], 4'($urandom),
                ($urandom % 8 == 0) ? 32'hFFFFFFF0 : $urandom);
      pre_valid  = ($urandom % 4) != 0;
      next_ready = ($urandom % 4) != 0;
      flush      = ($urandom % 20) == 0;
      #1;
      n = q.size();
      exp = '0;
      exp[129] = 1'b1;
      if (n >= 1) begin
        exp[131]      = 1'b1;
        exp[128]      = 1'b1;
        exp[127:96]   = q[0].inst;
        exp[63:32]    = q[0].pc;
      end
      if (n >= 2) begin
        exp[129]      = 1'b1;
        exp[95:64]    = q[1].inst;
        exp[31:0]     = q[1].pc;
      end
      exp[129] = (n >= 2);
      mfire  = (n > 0) && next_ready;
      mready = !flush && (n == 0 || (mfire && n <= 2));
      exp[130] = mready;
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL rand_cyc%0d got %h exp %h", cyc, obs, exp);
      end
`ifdef SPLITTER_PERF_CNT_EN
      checks++;
      if ({perf_issue_cnt, perf_stall_cnt} !== {m_issue, m_stall})
      begin
        errors++;
        $display("FAIL rand_perf%0d got %0d/%0d exp %0d/%0d", cyc,
                 perf_issue_cnt, perf_stall_cnt, m_issue, m_stall);
      end
`endif
      if (mfire) begin
        for (int k = 0; k < 2 && q.size() > 0; k++) begin
          void'(q.pop_front());
          m_issue++;
        end
      end
      if (n > 0 && !next_ready) m_stall++;
      if (flush) begin
        q.delete();
      end else if (pre_valid && mready) begin
        q.delete();
        for (int i = 0; i < 4; i++) begin
          if (inst_group_valid[i]) begin
            q.push_back('{inst: w[i], pc: group_pc + 32'(4 * i)});
          end
        end
      end
      tick();
    end
    flush     = 1'b0;
    pre_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_split();
    test_sparse();
    test_backpressure();
    test_flush();
    test_empty_wrap();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
